// File: rtl/c2c_rd_arbiter.sv
// Two-master read arbiter: instruction fetch (m0) and load (m1) share one memory read port.
// One transaction in flight; define C2C_ARB_RR_EN for round-robin ties, otherwise m1 has priority.
module c2c_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_ready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  input  logic              s_ready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                       state_reg;
  logic [ADDR_W-1:0]            addr_reg;
  logic                         grant_reg;
  logic                         s_valid_reg;
  logic                         win_next;
  logic                         grant_fire;
  logic                         resp_fire;
  logic [1:0]                   rvalid_vec;
  logic [1:0][DATA_W-1:0]       rdata_vec;

  assign grant_fire = (state_reg == IDLE) && (m0_valid || m1_valid);
  assign resp_fire  = (state_reg == RESP) && s_rvalid;

`ifdef C2C_ARB_RR_EN
  logic rr_last_reg;

  always_comb begin
    win_next = 1'b0;
    if (m1_valid && !m0_valid) begin
      win_next = 1'b1;
    end else if (m1_valid && m0_valid) begin
      win_next = ~rr_last_reg;
    end
  end

  // Reset value m1 makes the first tie go to m0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_last_reg <= 1'b1;
    end else if (grant_fire) begin
      rr_last_reg <= win_next;
    end
  end
`else
  // Load channel wins whenever it requests.
  always_comb win_next = m1_valid;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      grant_reg   <= 1'b0;
      s_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            addr_reg    <= win_next ? m1_addr : m0_addr;
            grant_reg   <= win_next;
            s_valid_reg <= 1'b1;
            state_reg   <= REQ;
          end
        end
        REQ: begin
          if (s_ready) begin
            s_valid_reg <= 1'b0;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          if (s_rvalid) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          s_valid_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      logic [DATA_W-1:0] rdata_reg;

      assign rvalid_vec[gi] = resp_fire && (grant_reg == 1'(gi));

      // Non-granted master keeps showing its last returned word.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rdata_reg <= '0;
        end else if (rvalid_vec[gi]) begin
          rdata_reg <= s_rdata;
        end
      end

      assign rdata_vec[gi] = rvalid_vec[gi] ? s_rdata : rdata_reg;
    end
  endgenerate

  assign m0_ready  = grant_fire && !win_next;
  assign m1_ready  = grant_fire && win_next;
  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];
  assign m0_rdata  = rdata_vec[0];
  assign m1_rdata  = rdata_vec[1];
  assign s_valid   = s_valid_reg;
  assign s_addr    = addr_reg;

endmodule

// File: tb/tb_c2c_rd_arbiter.sv
// Bench for c2c_rd_arbiter: directed scenarios then random traffic, all checked against a
// transaction-level model of grants, outstanding request and response routing.
module tb_c2c_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr;
  logic        s_ready = 1'b0, s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Model state: outstanding transaction, whether memory accepted it, its owner and address.
  bit          mdl_out = 0;
  bit          mdl_acc = 0;
  int          mdl_gnt = 0;
  int          mdl_last = 1;
  logic [31:0] mdl_addr = '0;
  logic [31:0] mdl_rd [2] = '{32'h0, 32'h0};

  bit obs_r0, obs_r1;

  c2c_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_ready(m0_ready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_ready(m1_ready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_ready(s_ready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef C2C_ARB_RR_EN
    return (mdl_last == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // One clock cycle: drive inputs after the edge, check outputs, then advance the model.
  task automatic cyc(input bit rn, input bit v0, input logic [31:0] a0,
                     input bit v1, input logic [31:0] a1,
                     input bit sr, input bit srv, input logic [31:0] sd);
    int w;
    bit exp_sv, resp, rv0, rv1;
    @(posedge clk);
    #1;
    reset_n = rn; m0_valid = v0; m0_addr = a0; m1_valid = v1; m1_addr = a1;
    s_ready = sr; s_rvalid = srv; s_rdata = sd;
    #1;
    cyc_n++;
    w = -1;
    if (!mdl_out && (v0 || v1)) w = winner(v0, v1);
    exp_sv = mdl_out && !mdl_acc;
    resp   = mdl_out && mdl_acc && srv;
    rv0    = resp && (mdl_gnt == 0);
    rv1    = resp && (mdl_gnt == 1);
    chk("m0_ready",  32'(m0_ready),  32'(w == 0));
    chk("m1_ready",  32'(m1_ready),  32'(w == 1));
    chk("s_valid",   32'(s_valid),   32'(exp_sv));
    chk("s_addr",    s_addr,         mdl_addr);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
    chk("m0_rdata",  m0_rdata,       rv0 ? sd : mdl_rd[0]);
    chk("m1_rdata",  m1_rdata,       rv1 ? sd : mdl_rd[1]);
    obs_r0 = m0_ready;
    obs_r1 = m1_ready;
    if (!rn) begin
      mdl_out = 0; mdl_acc = 0; mdl_gnt = 0; mdl_last = 1; mdl_addr = '0;
      mdl_rd[0] = '0; mdl_rd[1] = '0;
    end else if (w >= 0) begin
      mdl_out = 1; mdl_acc = 0; mdl_gnt = w; mdl_last = w;
      mdl_addr = (w == 1) ? a1 : a0;
    end else if (exp_sv && sr) begin
      mdl_acc = 1;
    end else if (resp) begin
      mdl_out = 0;
      mdl_rd[mdl_gnt] = sd;
      $display("xact m%0d addr %08h data %08h", mdl_gnt, mdl_addr, sd);
    end
  endtask

  initial begin
    int          t_first, t_second;
    bit          pend [2];
    logic [31:0] paddr [2];
    int          exp_tie [4];

    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_rdata0", m0_rdata, 32'h0);

    // Single fetch with zero-wait memory
    cyc(1, 1, 32'h100, 0, 0, 1, 0, 0);
    chk("t1_ready_c0", 32'(m0_ready), 32'h1);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_saddr_c1", s_addr, 32'h100);
    cyc(1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
    chk("t1_rdata_c2", m0_rdata, 32'hDEADBEEF);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // Repeated ties after a fresh reset
`ifdef C2C_ARB_RR_EN
    exp_tie = '{0, 1, 0, 1};
`else
    exp_tie = '{1, 1, 1, 1};
`endif
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 32'h1000 + 32'(k * 4), 1, 32'h2000 + 32'(k * 4), 1, 1, 32'hA000 + 32'(k));
      chk("t2_tie_winner", 32'(obs_r1), 32'(exp_tie[k]));
      cyc(1, 1, 32'h1000 + 32'(k * 4), 1, 32'h2000 + 32'(k * 4), 1, 1, 32'hB000 + 32'(k));
      cyc(1, 1, 32'h1000 + 32'(k * 4), 1, 32'h2000 + 32'(k * 4), 1, 1, 32'hC000 + 32'(k));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Memory stall for five cycles
    cyc(1, 1, 32'h340, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("t3_hold_addr", s_addr, 32'h340);
    end
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h12345678);
    chk("t3_rvalid", 32'(m0_rvalid), 32'h1);

    // Stray responses in IDLE and REQ
    cyc(1, 0, 0, 0, 0, 0, 1, 32'hBAD0);
    cyc(1, 0, 0, 1, 32'h400, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'hBAD1);
    chk("t4_no_rvalid", 32'(m1_rvalid), 32'h0);
    cyc(1, 0, 0, 0, 0, 1, 1, 32'hBAD2);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h55AA55AA);
    chk("t4_rdata", m1_rdata, 32'h55AA55AA);

    // Reset while awaiting the response
    cyc(1, 0, 0, 1, 32'h300, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'hDEAD0005);
    chk("t5_dropped", 32'(m1_rvalid), 32'h0);
    cyc(1, 0, 0, 1, 32'h308, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h0000C0DE);
    chk("t5_served", m1_rdata, 32'h0000C0DE);

    // Back-to-back loads
    t_first = -1; t_second = -1;
    cyc(1, 0, 0, 1, 32'h200, 1, 0, 0);
    if (obs_r1) t_first = cyc_n;
    for (int k = 0; k < 4 && t_second < 0; k++) begin
      cyc(1, 0, 0, 1, 32'h204, 1, 1, 32'h600 + 32'(k));
      if (obs_r1) t_second = cyc_n;
    end
    chk("t6_gap", 32'(t_second - t_first), 32'h3);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h777);

    // Random traffic
    pend[0] = 0; pend[1] = 0; paddr[0] = '0; paddr[1] = '0;
    for (int n = 0; n < 600; n++) begin
      bit rn;
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(2) == 0)) begin
          pend[m]  = 1;
          paddr[m] = $urandom() & 32'hFFFF_FFFC;
        end
      end
      rn = ($urandom_range(96) != 0);
      cyc(rn, pend[0], paddr[0], pend[1], paddr[1],
          $urandom_range(2) != 0, $urandom_range(2) == 0, $urandom());
      if (obs_r0) pend[0] = 0;
      if (obs_r1) pend[1] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
